fl_load_sequencer: RTL and testbench

FL_LOAD_SEQUENCER -- requirements
Module: fl_load_sequencer

---
 rtl/qracc_pkg.sv | 14 +
 rtl/fl_load_sequencer.sv | 146 ++++++++++++++
 tb/tb_fl_load_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/qracc_pkg.sv
// Shared types for the QRAcc feature-loader datapath.
package qracc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } fl_seq_state_t;

  localparam int FL_MASK_W = 10;

endpackage

// File: rtl/fl_load_sequencer.sv
// Streams ceil(N/CHUNK) activation-memory words into the feature-loader
// regfile, one request/response/write per chunk, then publishes the N window.
module fl_load_sequencer
  import qracc_pkg::*;
#(
  parameter int inputWidth   = 256,
  parameter int elementWidth = 8,
  parameter int numElements  = 128,
  parameter int addrWidth    = 8,
  parameter int memAddrWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [memAddrWidth-1:0] mem_base_i,
  input  logic [addrWidth:0]      fl_count_i,
  output logic                    mem_req_o,
  output logic [memAddrWidth-1:0] mem_addr_o,
  input  logic                    mem_ready_i,
  input  logic                    mem_rvalid_i,
  input  logic [inputWidth-1:0]   mem_rdata_i,
  output logic                    fl_wr_en_o,
  output logic [addrWidth-1:0]    fl_addr_o,
  output logic [inputWidth-1:0]   fl_data_o,
  output logic [FL_MASK_W-1:0]    mask_start_o,
  output logic [FL_MASK_W-1:0]    mask_end_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int CHUNK = inputWidth / elementWidth;
  localparam logic [addrWidth:0] NUM_E = (addrWidth+1)'(numElements);

  generate
    if (numElements % CHUNK != 0) begin : g_bad_depth
      $error("fl_load_sequencer: numElements must be a multiple of CHUNK");
    end
  endgenerate

  fl_seq_state_t             state_q, state_d;
  logic [memAddrWidth-1:0]   base_q, base_d;
  logic [addrWidth:0]        n_q, n_d;
  logic [addrWidth-1:0]      k_q, k_d;
  logic [inputWidth-1:0]     data_q, data_d;
  logic [FL_MASK_W-1:0]      mstart_q, mstart_d, mend_q, mend_d;
  logic                      err_q, err_d;
  logic [addrWidth:0]        n_clamp;
  logic [31:0]               chunk_end;
  logic                      last_chunk;
  logic                      start_acc;

  assign start_acc  = (state_q == IDLE) && start_i;
  assign n_clamp    = (fl_count_i > NUM_E) ? NUM_E : fl_count_i;
  // Last chunk once this chunk's end element reaches N; the tail past N
  // is still written and later hidden by the mask.
  assign chunk_end  = (32'(k_q) + 32'd1) * 32'(CHUNK);
  assign last_chunk = chunk_end >= 32'(n_q);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    n_d      = n_q;
    k_d      = k_q;
    data_d   = data_q;
    mstart_d = mstart_q;
    mend_d   = mend_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          base_d  = mem_base_i;
          n_d     = n_clamp;
          k_d     = '0;
          err_d   = 1'b0;
          state_d = (n_clamp == '0) ? DONE : REQ;
        end
      end
      REQ:   if (mem_ready_i) state_d = WAIT;
      WAIT: begin
        if (mem_rvalid_i) begin
          data_d  = mem_rdata_i;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (last_chunk) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = REQ;
        end
      end
      DONE: begin
        mstart_d = '0;
        mend_d   = FL_MASK_W'(n_q);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A response with no outstanding request is a protocol violation.
    if (mem_rvalid_i && (state_q != WAIT)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      n_q      <= '0;
      k_q      <= '0;
      data_q   <= '0;
      mstart_q <= '0;
      mend_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      n_q      <= n_d;
      k_q      <= k_d;
      data_q   <= data_d;
      mstart_q <= mstart_d;
      mend_q   <= mend_d;
      err_q    <= err_d;
    end
  end

`ifdef TRACK_STATISTICS
  logic [31:0] stat_loads_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            stat_loads_q <= '0;
    else if (start_acc) stat_loads_q <= stat_loads_q + 32'd1;
  end
`endif

  assign mem_req_o    = (state_q == REQ);
  assign mem_addr_o   = mem_req_o ? (base_q + memAddrWidth'(k_q)) : '0;
  assign fl_wr_en_o   = (state_q == WRITE);
  assign fl_addr_o    = fl_wr_en_o ? addrWidth'(32'(k_q) * 32'(CHUNK)) : '0;
  assign fl_data_o    = data_q;
  assign mask_start_o = mstart_q;
  assign mask_end_o   = mend_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_fl_load_sequencer.sv
// Randomized bench: a memory responder with random handshake delays, checked
// against the chunking rules (N clamp, ceil(N/CHUNK), base+k, k*CHUNK).
module tb_fl_load_sequencer;
  localparam int IW = 256;
  localparam int NE = 128;
  localparam int AW = 8;
  localparam int MW = 16;
  localparam int CH = 32;

  logic          clk, rst;
  logic          start_i;
  logic [MW-1:0] mem_base_i;
  logic [AW:0]   fl_count_i;
  logic          mem_req_o;
  logic [MW-1:0] mem_addr_o;
  logic          mem_ready_i, mem_rvalid_i;
  logic [IW-1:0] mem_rdata_i;
  logic          fl_wr_en_o;
  logic [AW-1:0] fl_addr_o;
  logic [IW-1:0] fl_data_o;
  logic [9:0]    mask_start_o, mask_end_o;
  logic          busy_o, done_o, err_o;

  fl_load_sequencer #(
    .inputWidth(IW), .elementWidth(8), .numElements(NE),
    .addrWidth(AW), .memAddrWidth(MW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mem_base_i(mem_base_i),
    .fl_count_i(fl_count_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .fl_wr_en_o(fl_wr_en_o), .fl_addr_o(fl_addr_o),
    .fl_data_o(fl_data_o), .mask_start_o(mask_start_o), .mask_end_o(mask_end_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  logic [9:0] exp_mend;

  always @(negedge clk) if (fl_wr_en_o) wr_cnt++;

  task automatic chk(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] rnd_word();
    logic [IW-1:0] w;
    for (int i = 0; i < IW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic load(input logic [MW-1:0] base, input int cnt, input int rdmax,
                      input int d2max, input bit inject, input int abort_c);
    int n, nch, wr0, rd, d2;
    logic [MW-1:0] ea;
    logic [IW-1:0] d;
    n   = (cnt > NE) ? NE : cnt;
    nch = (n + CH - 1) / CH;
    wr0 = wr_cnt;
    cyc;
    start_i = 1'b1; mem_base_i = base; fl_count_i = 9'(cnt);
    cyc;
    start_i = 1'b0;
    if (n == 0) begin
      @(negedge clk);
      chk("done0", done_o, 1);
      chk("noreq0", mem_req_o, 0);
      chk("nowr0", fl_wr_en_o, 0);
      cyc;
      @(negedge clk);
      chk("done0_1cyc", done_o, 0);
      chk("busy0", busy_o, 0);
      chk("mend0", mask_end_o, 0);
      exp_mend = 10'd0;
      return;
    end
    for (int c = 0; c < nch; c++) begin
      rd = $urandom_range(rdmax, 0);
      d2 = $urandom_range(d2max, 0);
      ea = base + MW'(c);
      @(negedge clk);
      chk("req", mem_req_o, 1);
      chk("maddr", mem_addr_o, ea);
      if (c == 0) begin
        chk("busy", busy_o, 1);
        chk("err_clr", err_o, 0);
      end
      for (int i = 0; i < rd; i++) begin
        if (inject && i == 0) begin start_i = 1'b1; fl_count_i = 9'd7; end
        cyc;
        start_i = 1'b0;
        @(negedge clk);
        chk("req_hold", mem_req_o, 1);
        chk("maddr_hold", mem_addr_o, ea);
      end
      mem_ready_i = 1'b1;
      cyc;
      mem_ready_i = 1'b0;
      if (c == abort_c) begin
        #2 rst = 1'b1;
        @(negedge clk);
        chk("ab_req", mem_req_o, 0);
        chk("ab_maddr", mem_addr_o, 0);
        chk("ab_wr", fl_wr_en_o, 0);
        chk("ab_faddr", fl_addr_o, 0);
        chk("ab_fdata", fl_data_o, 0);
        chk("ab_mend", mask_end_o, 0);
        chk("ab_busy", busy_o, 0);
        chk("ab_done", done_o, 0);
        chk("ab_err", err_o, 0);
        cyc;
        rst = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = rnd_word();
        cyc;
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("stray_err", err_o, 1);
        chk("stray_busy", busy_o, 0);
        chk("stray_nowr", fl_wr_en_o, 0);
        chk("ab_wrcnt", wr_cnt - wr0, abort_c);
        exp_mend = 10'd0;
        return;
      end
      for (int i = 0; i < d2; i++) begin
        @(negedge clk);
        chk("wait_noreq", mem_req_o, 0);
        chk("wait_nowr", fl_wr_en_o, 0);
        cyc;
      end
      d = rnd_word();
      mem_rvalid_i = 1'b1; mem_rdata_i = d;
      cyc;
      mem_rvalid_i = 1'b0;
      @(negedge clk);
      chk("wr_en", fl_wr_en_o, 1);
      chk("faddr", fl_addr_o, c * CH);
      chk("fdata", fl_data_o, d);
      chk("mend_hold", mask_end_o, exp_mend);
      cyc;
    end
    @(negedge clk);
    chk("done", done_o, 1);
    chk("mend_pre", mask_end_o, exp_mend);
    cyc;
    @(negedge clk);
    chk("done_1cyc", done_o, 0);
    chk("idle", busy_o, 0);
    chk("mend", mask_end_o, n);
    chk("mstart", mask_start_o, 0);
    chk("wrcnt", wr_cnt - wr0, nch);
    chk("noerr", err_o, 0);
    exp_mend = 10'(n);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; mem_base_i = '0; fl_count_i = '0;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    exp_mend = 10'd0;
    cyc; cyc;
    @(negedge clk);
    chk("rst_req", mem_req_o, 0);
    chk("rst_maddr", mem_addr_o, 0);
    chk("rst_wr", fl_wr_en_o, 0);
    chk("rst_fdata", fl_data_o, 0);
    chk("rst_mend", mask_end_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    cyc;
    rst = 1'b0;

    load(16'h0100, 128, 0, 0, 1'b0, -1);
    load(16'h0200, 40, 1, 1, 1'b0, -1);
    load(16'h0300, 0, 0, 0, 1'b0, -1);
    load(16'h0400, 96, 5, 3, 1'b1, -1);
    load(16'h0500, 200, 2, 2, 1'b0, -1);
    load(16'h0600, 128, 1, 1, 1'b0, 2);
    load(16'hFFFE, 100, 2, 2, 1'b1, -1);
    for (int t = 0; t < 12; t++)
      load(MW'($urandom), int'($urandom_range(200, 0)), 3, 3, 1'($urandom), -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
